// File: rtl/sr_bank_if.sv
// Request/acknowledge bundle between two requesters and the SR bank controller.
// Handshake: a requester holds req with op/idx stable until its one-cycle ack;
// the controller samples op/idx only at the grant edge.
interface sr_bank_if #(
    parameter int IW = 2
);
    logic          a_req;
    logic [1:0]    a_op;
    logic [IW-1:0] a_idx;
    logic          a_ack;
    logic          b_req;
    logic [1:0]    b_op;
    logic [IW-1:0] b_idx;
    logic          b_ack;

    modport master (
        output a_req, a_op, a_idx, b_req, b_op, b_idx,
        input  a_ack, b_ack
    );

    modport slave (
        input  a_req, a_op, a_idx, b_req, b_op, b_idx,
        output a_ack, b_ack
    );
endinterface

// File: rtl/sr_bank_ctrl.sv
// Two-requester, round-robin controller that pulses set/reset strobes into an
// external bank of SR flops and mirrors the commanded cell states on q.
module sr_bank_ctrl #(
    parameter int N     = 4,
    parameter int PULSE = 2,
    parameter int IW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    sr_bank_if.slave     bus,
    output logic [N-1:0] s_out,
    output logic [N-1:0] r_out,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         err,
    output logic [1:0]   state_dbg
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [IW:0] N_L = (IW+1)'(N);

    logic [1:0]    state;
    logic          ptr;      // 0: A holds priority, 1: B holds priority
    logic [3:0]    cnt;
    logic [1:0]    op_r;
    logic [IW-1:0] idx_r;
    logic          id_r;     // 0: A owns the operation, 1: B owns it

    logic          grant_b;
    logic          idx_ok;
    logic          strobe_op;
    logic [N-1:0]  onehot;

    assign grant_b   = bus.b_req && (!bus.a_req || ptr);
    assign idx_ok    = {1'b0, idx_r} < N_L;
    assign strobe_op = idx_ok && (op_r == OP_SET || op_r == OP_CLR);
    assign onehot    = {{(N-1){1'b0}}, 1'b1} << idx_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= 4'd0;
            op_r  <= OP_NOP;
            idx_r <= '0;
            id_r  <= 1'b0;
            q     <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        op_r  <= grant_b ? bus.b_op  : bus.a_op;
                        idx_r <= grant_b ? bus.b_idx : bus.a_idx;
                        id_r  <= grant_b;
                        ptr   <= !grant_b;
                        cnt   <= 4'(PULSE - 1);
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Strobe-less operations leave after a single cycle.
                    if (cnt == 4'd0 || !strobe_op) begin
                        state <= DONE;
                        if (strobe_op)
                            q <= (op_r == OP_SET) ? (q | onehot) : (q & ~onehot);
                        if (op_r == OP_ILL || !idx_ok)
                            err <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so a reset drops them at once.
    assign s_out     = (state == DRIVE && strobe_op && op_r == OP_SET) ? onehot : '0;
    assign r_out     = (state == DRIVE && strobe_op && op_r == OP_CLR) ? onehot : '0;
    assign bus.a_ack = (state == DONE) && !id_r;
    assign bus.b_ack = (state == DONE) && id_r;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl: main instance N=4, second instance N=3 for
// out-of-range indices; an ack-order queue and strobe invariants run every cycle.
module tb_sr_bank_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_bank_if #(.IW(2)) bus ();
  sr_bank_if #(.IW(2)) bus3 ();

  logic [3:0] s_out, r_out, q;
  logic       busy, err;
  logic [1:0] state_dbg;
  logic [2:0] s3, r3, q3;
  logic       busy3, err3;
  logic [1:0] st3;

  sr_bank_ctrl #(.N(4), .PULSE(2), .IW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .s_out(s_out), .r_out(r_out), .q(q),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  sr_bank_ctrl #(.N(3), .PULSE(2), .IW(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .s_out(s3), .r_out(r3), .q(q3),
    .busy(busy3), .err(err3), .state_dbg(st3)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_state", state_dbg, 0);
    check("rst_q", q, 0);
    check("rst_s", s_out, 0);
    check("rst_r", r_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ack", {bus.a_ack, bus.b_ack}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_reset_state();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    check("excl", s_out & r_out, 0);
    check("onehot0", ($countones(s_out | r_out) <= 1), 1);
    check("excl3", s3 & r3, 0);
    check("ack_both", bus.a_ack & bus.b_ack, 0);
    if (bus.a_ack || bus.b_ack) begin
      if (exp_q.size() == 0) check("ack_unexpected", {bus.a_ack, bus.b_ack}, 0);
      else check("ack_order", bus.b_ack, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acks;
    rst = 1'b1;
    bus.a_req = 0; bus.a_op = 0; bus.a_idx = 0;
    bus.b_req = 0; bus.b_op = 0; bus.b_idx = 0;
    bus3.a_req = 0; bus3.a_op = 0; bus3.a_idx = 0;
    bus3.b_req = 0; bus3.b_op = 0; bus3.b_idx = 0;
    tick(2);
    check_reset_state();
    rst = 1'b0;

    // Set cell 2
    bus.a_req = 1; bus.a_op = 2'b10; bus.a_idx = 2; exp_q.push_back(1'b0);
    tick(); check("t1_s1", s_out, 4'b0100); check("t1_busy", busy, 1); check("t1_drive", state_dbg, 1);
    tick(); check("t1_s2", s_out, 4'b0100);
    tick(); check("t1_ack", bus.a_ack, 1); check("t1_s3", s_out, 0); check("t1_q", q, 4'b0100);
    check("t1_done", state_dbg, 2);
    bus.a_req = 0;
    tick(); check("t1_idle", busy, 0); check("t1_ack_low", bus.a_ack, 0);

    // Simultaneous set/clear of cell 1 after reset: A first, then B
    do_reset();
    bus.a_req = 1; bus.a_op = 2'b10; bus.a_idx = 1;
    bus.b_req = 1; bus.b_op = 2'b01; bus.b_idx = 1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    tick(); check("t2_s1", s_out, 4'b0010); check("t2_r1", r_out, 0);
    tick(); check("t2_s2", s_out, 4'b0010);
    tick(); check("t2_a_ack", bus.a_ack, 1); check("t2_q_set", q, 4'b0010);
    bus.a_req = 0;
    tick(); check("t2_idle", state_dbg, 0); check("t2_no_back", bus.b_ack, 0);
    tick(); check("t2_r_a", r_out, 4'b0010); check("t2_s_off", s_out, 0);
    tick(); check("t2_r_b", r_out, 4'b0010);
    tick(); check("t2_b_ack", bus.b_ack, 1); check("t2_q_clr", q, 4'b0000);
    bus.b_req = 0;
    tick(); check("t2_end", busy, 0);

    // Fairness: both held for six operations, grants must alternate
    bus.a_req = 1; bus.a_op = 2'b10; bus.a_idx = 0;
    bus.b_req = 1; bus.b_op = 2'b10; bus.b_idx = 3;
    for (int i = 0; i < 3; i++) begin exp_q.push_back(1'b0); exp_q.push_back(1'b1); end
    acks = 0;
    for (int i = 0; i < 40 && acks < 6; i++) begin
      tick();
      if (bus.a_ack || bus.b_ack) acks++;
    end
    bus.a_req = 0; bus.b_req = 0;
    check("t3_acks", acks, 6);
    tick(); check("t3_q", q, 4'b1001); check("t3_idle", busy, 0);

    // Illegal op from B
    bus.b_req = 1; bus.b_op = 2'b11; bus.b_idx = 0; exp_q.push_back(1'b1);
    tick(); check("t4_s", s_out, 0); check("t4_r", r_out, 0); check("t4_busy", busy, 1);
    tick(); check("t4_ack", bus.b_ack, 1); check("t4_err", err, 1); check("t4_q", q, 4'b1001);
    bus.b_req = 0;
    tick();
    // Legal clear afterwards: err stays sticky
    bus.a_req = 1; bus.a_op = 2'b01; bus.a_idx = 0; exp_q.push_back(1'b0);
    tick(); check("t4_r_clr", r_out, 4'b0001);
    tick(2); check("t4_ack2", bus.a_ack, 1); check("t4_q2", q, 4'b1000); check("t4_err_sticky", err, 1);
    bus.a_req = 0;
    tick();
    // Nop from A, req dropped before ack
    bus.a_req = 1; bus.a_op = 2'b00; bus.a_idx = 1; exp_q.push_back(1'b0);
    tick(); check("t5_nop_strobe", s_out | r_out, 0); check("t5_busy", busy, 1);
    bus.a_req = 0;
    tick(); check("t5_ack", bus.a_ack, 1); check("t5_q", q, 4'b1000); check("t5_err", err, 1);
    tick();
    // Pointer now at B after the nop grant to A
    bus.a_req = 1; bus.a_op = 2'b00; bus.b_req = 1; bus.b_op = 2'b00;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    tick(2); check("t6_b_first", bus.b_ack, 1);
    bus.b_req = 0;
    tick(3); check("t6_a_next", bus.a_ack, 1);
    bus.a_req = 0;
    tick();

    // Reset during the second DRIVE cycle of a set
    bus.a_req = 1; bus.a_op = 2'b10; bus.a_idx = 1;
    tick(); check("t7_s1", s_out, 4'b0010);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t7_s_drop", s_out, 0); check("t7_state", state_dbg, 0);
    check("t7_q", q, 0); check("t7_err", err, 0); check("t7_busy", busy, 0);
    bus.a_req = 0;
    tick(); check("t7_no_ack", {bus.a_ack, bus.b_ack}, 0);
    bus.b_req = 1; bus.b_op = 2'b10; bus.b_idx = 3; exp_q.push_back(1'b1);
    rst = 1'b0;
    tick(); check("t7_first_grant", state_dbg, 1); check("t7_s_b", s_out, 4'b1000);
    tick(2); check("t7_b_ack", bus.b_ack, 1); check("t7_q_b", q, 4'b1000);
    bus.b_req = 0;
    tick();

    // N=3 instance: index 3 out of range, then a legal set of cell 2
    bus3.a_req = 1; bus3.a_op = 2'b10; bus3.a_idx = 3;
    tick(); check("t8_s", s3, 0); check("t8_r", r3, 0); check("t8_busy", busy3, 1);
    tick(); check("t8_ack", bus3.a_ack, 1); check("t8_err", err3, 1); check("t8_q", q3, 0);
    bus3.a_req = 0;
    tick();
    bus3.a_req = 1; bus3.a_op = 2'b10; bus3.a_idx = 2;
    tick(); check("t8_s_ok", s3, 3'b100);
    tick(2); check("t8_ack2", bus3.a_ack, 1); check("t8_q2", q3, 3'b100); check("t8_err2", err3, 1);
    bus3.a_req = 0;
    tick();

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sr_bank_ctrl.md
SR_BANK_CTRL -- requirements
Module: sr_bank_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: number of SR cells controlled; range 2..16.
REQ-002 SHALL have parameter PULSE, default 2: cycles s_out/r_out are held per operation; range 1..15.
REQ-003 SHALL have parameter IW, default 2: index width; IW = clog2(N).
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port a_req, input, 1: requester A request; held until a_ack.
REQ-007 SHALL have port a_op, input, 2: 00 nop, 01 clear, 10 set, 11 illegal.
REQ-008 SHALL have port a_idx, input, IW: target cell for requester A.
REQ-009 SHALL have port a_ack, output, 1: one-cycle completion pulse to A.
REQ-010 SHALL have ports b_req, b_op, b_idx and b_ack: identical to requester A, for requester B.
REQ-011 SHALL have port s_out, output, N: set strobes to the external SR flop bank.
REQ-012 SHALL have port r_out, output, N: reset strobes to the external SR flop bank.
REQ-013 SHALL have port q, output, N: mirror of the commanded state of each cell.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port err, output, 1: sticky flag for an illegal op or out-of-range index.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE and DONE.
REQ-017 IDLE: with any req high, SHALL arbitrate, latch the winner's op/idx/id, and go to DRIVE on the next edge; with no req, SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin with one priority pointer, reset value A.
- Both requesting: the pointer holder wins.
- Single requester: wins regardless of the pointer.
- The pointer SHALL move to the non-granted requester after every grant.
REQ-019 DRIVE with latched op 10: SHALL hold s_out[idx]=1 for exactly PULSE cycles; all other s_out/r_out bits SHALL be 0.
REQ-020 DRIVE with latched op 01: SHALL hold r_out[idx]=1 for exactly PULSE cycles; all other bits SHALL be 0.
REQ-021 DRIVE with latched op 00, op 11, or idx >= N: SHALL drive no strobe and last 1 cycle.
- Op 11 or idx >= N SHALL set err.
REQ-022 A down-counter SHALL sequence DRIVE: loaded with PULSE-1 on entry; exit to DONE when it reads 0.
REQ-023 DONE: SHALL last one cycle, assert the winner's ack, then return to IDLE.
- Set/clear: q[idx] SHALL update on the edge entering DONE (set -> 1, clear -> 0).
- Nop/illegal: q SHALL be unchanged.
REQ-024 Invariant: (s_out & r_out) SHALL be 0 in every cycle; at most one bit of (s_out | r_out) SHALL be high.
REQ-025 Latency: from req sampled in IDLE to ack high SHALL be PULSE+1 cycles for set/clear and 2 cycles for nop/illegal.
REQ-026 Latched op/idx SHALL be immune to requester input changes after the grant.
REQ-027 The losing requester SHALL keep req high.
- It SHALL be granted in the IDLE cycle following the DONE cycle.
- Max wait SHALL be one full operation.
REQ-028 A req dropped before ack SHALL NOT abort a granted operation; the ack is still issued.
REQ-029 A nop SHALL still consume a grant and advance the pointer.
REQ-030 The block SHALL NOT sample req in the DONE cycle.
- A requester that keeps req high after its ack is treated as a new request in IDLE.
REQ-031 err SHALL clear only on rst.

Reset
REQ-032 While rst=1, regardless of clk, the block SHALL force:
- state IDLE, pointer A, counter 0;
- s_out=0, r_out=0, q=0, a_ack=0, b_ack=0, busy=0, err=0.
REQ-033 Reset mid-DRIVE SHALL drop strobes immediately and discard the operation with no ack.
REQ-034 After rst falls, the first rising edge SHALL be able to grant.

Verification
REQ-035 Set cell 2, N=4, PULSE=2: a_req=1, a_op=10, a_idx=2 -> s_out=0100 for 2 cycles, a_ack pulse at cycle 3, q=0100.
REQ-036 Simultaneous set/clear: a_req/b_req both high after reset, A op 10 idx1, B op 01 idx1 -> A served first (q[1]=1), then B (r_out=0010 for 2 cycles, q[1]=0); the s_out&r_out=0 check SHALL pass in every cycle.
REQ-037 Fairness: both requesters held high continuously for 6 operations -> grants strictly alternate A,B,A,B,A,B.
REQ-038 Illegal op: b_op=11 -> no strobe, b_ack after 2 cycles, err=1 and sticky through later legal ops, q unchanged.
REQ-039 Reset mid-operation: assert rst during the 2nd DRIVE cycle of a set -> s_out=0 immediately, no ack, q=0; the next request is served normally.
REQ-040 Out-of-range index, N=3, IW=2: a_idx=3 -> err=1, no strobe, ack after 2 cycles.
